// File: rtl/gated_rr_sink_arbiter_pkg.sv
// Shared types and defaults for the gated round-robin sink arbiter.
package gated_arb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPT = 2'd1, HOLD = 2'd2} state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int DW_DEF       = 8;
  localparam int HOLD_CYC_DEF = 2;

  // Reference pick at the default geometry: first set bit at or after ptr, wrapping.
  function automatic logic [N_REQ_DEF-1:0] rr_pick(
    input logic [N_REQ_DEF-1:0]         req,
    input logic [$clog2(N_REQ_DEF)-1:0] ptr
  );
    logic [N_REQ_DEF-1:0] oh;
    int j;
    oh = '0;
    for (int k = N_REQ_DEF - 1; k >= 0; k--) begin
      j = (k + int'(ptr)) % N_REQ_DEF;
      if (req[j]) begin
        oh = '0;
        oh[j] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/gated_rr_sink_arbiter_if.sv
// Request/data/sink bundle between the requesters and the arbiter.
interface gated_rr_sink_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0][DW-1:0] data_in;
  logic                     gate;
  logic [N_REQ-1:0]         gnt;
  logic                     out_valid;
  logic [DW-1:0]            out_data;
  logic                     busy;

  modport master (output req, data_in, gate, input gnt, out_valid, out_data, busy);
  modport slave  (input req, data_in, gate, output gnt, out_valid, out_data, busy);
endinterface

// File: rtl/gated_rr_sink_arbiter_rr_pick_onehot.sv
// Round-robin one-hot picker: rotate by ptr, isolate lowest set bit, rotate back.
module rr_pick_onehot #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] rot, pe;

  always_comb begin
    rot = '0;
    gnt = '0;
    for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
    pe = rot & (~rot + N'(1));
    for (int i = 0; i < N; i++) gnt[(i + int'(ptr)) % N] = pe[i];
  end
endmodule

// File: rtl/gated_rr_sink_arbiter.sv
// Round-robin arbiter feeding one registered, gateable sink word.
// Define GATED_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (ptr pinned at 0).
module gated_rr_sink_arbiter
  import gated_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input logic clk,
  input logic rst_n,
  gated_rr_sink_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYC) + 1;

  state_e           state, nstate;
  logic [PW-1:0]    ptr, win, win_d;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    word, od_d, od_q;
  logic [N_REQ-1:0] pick, gnt_d, gnt_q;
  logic             ov_d, ov_q;

  rr_pick_onehot #(.N(N_REQ)) u_pick (.req(bus.req), .ptr(ptr), .gnt(pick));

  always_comb begin
    win_d = '0;
    for (int i = 0; i < N_REQ; i++) if (pick[i]) win_d = PW'(i);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nstate;

  // A HOLD cycle only counts toward the window if it actually showed the word.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (|bus.req) nstate = CAPT;
      CAPT:    nstate = HOLD;
      HOLD:    if (ov_q && cnt == '0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // gate is sampled at the edge and masks the sink for the following cycle.
  always_comb begin
    gnt_d = (state == IDLE) ? pick : '0;
    ov_d  = (nstate == HOLD) && !bus.gate;
    od_d  = '0;
    if (ov_d) od_d = (state == CAPT) ? bus.data_in[win] : word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      win   <= '0;
      word  <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      gnt_q <= gnt_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      if (state == IDLE && |bus.req) win <= win_d;
      if (state == CAPT) begin
        word <= bus.data_in[win];
        cnt  <= CW'(HOLD_CYC - 1);
      end
      if (state == HOLD && ov_q) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
`ifdef GATED_ARB_FIXED_PRIO_EN
        ptr <= '0;
`else
        else ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
`endif
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_gated_rr_sink_arbiter.sv
// Directed bench for gated_rr_sink_arbiter with a per-cycle reference model.
module tb_gated_rr_sink_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int HC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gated_rr_sink_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();
  gated_rr_sink_arbiter #(.N_REQ(N), .DW(DW), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 grant cycle, 2 showing; 'left' = shows still owed.
  int            m_mode, m_left, m_ptr, m_win;
  logic [DW-1:0] m_word;
  logic [N-1:0]  e_gnt;
  logic          e_ov, e_busy;
  logic [DW-1:0] e_od;

  always @(posedge clk or negedge rst_n) begin : model
    int mode, left, ptr, win;
    logic [DW-1:0] word;
    logic ov, found;
    logic [N-1:0] g;
    if (!rst_n) begin
      m_mode <= 0; m_left <= 0; m_ptr <= 0; m_win <= 0; m_word <= '0;
      e_gnt <= '0; e_ov <= 1'b0; e_od <= '0; e_busy <= 1'b0;
    end else begin
      mode = m_mode; left = m_left; ptr = m_ptr; win = m_win; word = m_word;
      g = '0; ov = 1'b0; found = 1'b0;
      case (mode)
        0: for (int k = 0; k < N; k++) begin
             if (!found && bus.req[(ptr + k) % N]) begin
               found = 1'b1; win = (ptr + k) % N; g[win] = 1'b1; mode = 1;
             end
           end
        1: begin word = bus.data_in[win]; left = HC; mode = 2; ov = !bus.gate; end
        default: begin
          if (e_ov) left = left - 1;
          if (left == 0) begin
            mode = 0;
`ifndef GATED_ARB_FIXED_PRIO_EN
            ptr = (win + 1) % N;
`endif
          end else ov = !bus.gate;
        end
      endcase
      m_mode <= mode; m_left <= left; m_ptr <= ptr; m_win <= win; m_word <= word;
      e_gnt <= g; e_ov <= ov; e_od <= ov ? word : '0; e_busy <= (mode != 0);
    end
  end

  always @(negedge clk) begin
    chk("cyc_gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("cyc_out_valid", 32'(bus.out_valid), 32'(e_ov));
    chk("cyc_out_data", 32'(bus.out_data), 32'(e_od));
    chk("cyc_busy", 32'(bus.busy), 32'(e_busy));
  end

  task automatic wait_gnt(input int maxc);
    int n = 0;
    while (bus.gnt == '0 && n < maxc) begin @(negedge clk); n++; end
    chk("gnt_timeout", 32'(bus.gnt != '0), 32'd1);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (bus.busy && n < maxc) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    bus.req = '0; bus.gate = 1'b0;
    for (int i = 0; i < N; i++) bus.data_in[i] = '0;
    do_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);

    // 1: single request, basic latency
    bus.req = 4'b0001; bus.data_in[0] = 8'hA5;
    @(negedge clk);
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    @(negedge clk);
    chk("t1_ov0", 32'(bus.out_valid), 32'd1);
    chk("t1_od0", 32'(bus.out_data), 32'hA5);
    @(negedge clk);
    chk("t1_od1", 32'(bus.out_data), 32'hA5);
    @(negedge clk);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_ov_end", 32'(bus.out_valid), 32'd0);

    // 2: all requesting, rotation with wrap
    do_reset();
    bus.data_in[0] = 8'h11; bus.data_in[1] = 8'h22;
    bus.data_in[2] = 8'h33; bus.data_in[3] = 8'h44;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(8);
      chk("t2_gnt", 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
      if (g == 4) bus.req = '0;
      d = 8'h11 * 8'((g % 4) + 1);
      @(negedge clk); chk("t2_od0", 32'(bus.out_data), 32'(d));
      @(negedge clk); chk("t2_od1", 32'(bus.out_data), 32'(d));
    end
    wait_idle(8);

    // 3: gate stalls the hold window for three cycles
    bus.data_in[2] = 8'h5C; bus.req = 4'b0100;
    wait_gnt(8);
    chk("t3_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0; bus.gate = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_gated_ov", 32'(bus.out_valid), 32'd0);
      chk("t3_gated_od", 32'(bus.out_data), 32'd0);
      chk("t3_gated_busy", 32'(bus.busy), 32'd1);
    end
    bus.gate = 1'b0;
    @(negedge clk); chk("t3_od0", 32'(bus.out_data), 32'h5C);
    @(negedge clk); chk("t3_od1", 32'(bus.out_data), 32'h5C);
    @(negedge clk); chk("t3_busy", 32'(bus.busy), 32'd0);

    // 4: request pulsed only outside IDLE is dropped
    bus.req = 4'b0001;
    wait_gnt(8);
    chk("t4_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = '0;
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_gnt", 32'(bus.gnt), 32'd0);
    end
    chk("t4_busy", 32'(bus.busy), 32'd0);

    // 5: reset mid-HOLD clears outputs at once and ptr
    bus.data_in[2] = 8'h77; bus.req = 4'b0100;
    wait_gnt(8);
    chk("t5_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    @(negedge clk);
    chk("t5_od", 32'(bus.out_data), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_od", 32'(bus.out_data), 32'd0);
    chk("t5_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_regnt", 32'(bus.gnt), 32'd0);
    end
    bus.req = 4'b1111;
    wait_gnt(8);
    chk("t5_ptr0", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    wait_idle(8);

    // 6: req=1010 held: fixed priority always picks 1, round-robin alternates
    do_reset();
    bus.req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(8);
`ifdef GATED_ARB_FIXED_PRIO_EN
      chk("t6_gnt", 32'(bus.gnt), 32'h2);
`else
      chk("t6_gnt", 32'(bus.gnt), (g % 2 == 0) ? 32'h2 : 32'h8);
`endif
      @(negedge clk);
    end
    bus.req = '0;
    wait_idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
